park_gate_ctrl: RTL and testbench
=================================

Name: park_gate_ctrl

Overview:
- Entry/exit barrier controller for the parking lot.
- Sits directly upstream of the floor-allocation FSM and produces its 4-bit occupancy `count` (0..12).
- Sequences one entry barrier and one exit barrier from loop and beam sensors, and admits cars only while occupancy is below capacity.
- Keeps the saturating occupancy counter.

Parameters:
- CAPACITY, 12, maximum number of cars; count never exceeds it.
- CNT_W, 4, width of count; must hold CAPACITY.
- GATE_TIMEOUT, 16, cycles a barrier stays open waiting for its beam before closing without a count change.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- entry_req  input  1  car present on entry loop (level)
- entry_pass  input  1  entry beam broken (level)
- exit_req  input  1  car present on exit loop (level)
- exit_pass  input  1  exit beam broken (level)
- count  output  CNT_W  current occupancy, registered
- entry_open  output  1  entry barrier raised
- exit_open  output  1  exit barrier raised
- entry_denied  output  1  one-cycle pulse: entry request refused, lot full
- gate_timeout  output  1  one-cycle pulse: a barrier closed on timeout
- exit_err  output  1  one-cycle pulse: exit pass seen with count==0

Behaviour:
- Interface: one clock `clk`. `rst` is synchronous and active-high, sampled on posedge clk.
- Reset values: count=0, entry_open=0, exit_open=0, all pulses 0, both FSMs in IDLE, timers 0, edge registers 0.
- Sensor inputs are already synchronous. Each input has a registered previous value.
- A "rise" is input=1 while its previous value=0, evaluated at the sampling edge.
- Two independent, identical-form FSMs (entry, exit), with states IDLE, OPEN, CLOSE:
  - IDLE -> OPEN on req rise. Entry additionally requires count < CAPACITY.
  - Entry: req rise with count == CAPACITY stays IDLE and pulses entry_denied for 1 cycle.
  - OPEN: timer increments each cycle.
    - pass rise -> CLOSE, count updated at the same edge.
    - timer == GATE_TIMEOUT-1 with no pass rise -> IDLE, gate_timeout pulse, count unchanged.
  - CLOSE -> IDLE unconditionally after 1 cycle. req/pass rises during CLOSE are ignored.
  - req rises while OPEN are ignored.
  - Timer clears on every OPEN entry.
- Outputs are registered decodes of state: entry_open=1 only in entry OPEN; exit_open=1 only in exit OPEN.
  - Latency: req rise sampled at edge N -> open=1 after edge N.
- Count arithmetic, evaluated on the same edge:
  - Increment on entry pass-rise-in-OPEN.
  - Decrement on exit pass-rise-in-OPEN.
  - Both in the same cycle -> count unchanged.
  - Increment saturates at CAPACITY. This cannot occur normally because admission is checked.
  - Decrement at count==0 leaves count 0 and pulses exit_err.
- Only one entry can be pending, so checking count < CAPACITY at admission is sufficient.
- An exit in progress does not reserve or release capacity until its pass.
- Pass edges outside OPEN never change count.
- gate_timeout is the OR of both FSMs' timeout events, one pulse even if both time out together.
- Reset mid-operation: barriers close on the next edge and count returns to 0. No pulses are generated by the reset itself.

Optional Feature:
- Macro: PARK_GATE_STATS_EN.
- When defined, adds two ports, both cleared by rst and read directly from registers:
  - total_entries, output, 16 bits: wrapping count of completed entries.
  - total_denied, output, 16 bits: wrapping count of entry_denied pulses.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Test Plan:
- Reset, then entry_req rise and entry_pass rise 3 cycles later:
  - entry_open=1 one cycle after the req edge.
  - count 0->1 on the pass edge.
  - entry_open=0 for the CLOSE cycle and afterwards.
- Twelve full entry sequences, then a 13th entry_req:
  - count reaches 12.
  - 13th request gives a single entry_denied pulse, entry_open stays 0, count stays 12.
- Count=12, then exit sequence, then entry sequence:
  - count 12->11 on exit_pass.
  - Entry now admitted, count returns to 12.
- Entry req with no pass:
  - entry_open high for exactly 16 cycles.
  - gate_timeout pulses once, count unchanged.
- Count=5, entry_pass rise and exit_pass rise on the same edge, both gates OPEN: count stays 5 and both FSMs go to CLOSE.
- Count=0, exit sequence: count stays 0 and exit_err pulses once. Then assert rst while entry_open=1: next cycle entry_open=0 and count=0.

Source files
------------

// File: rtl/park_gate_ctrl.sv
// Parking lot entry/exit barrier controller with saturating occupancy count.
// Optional statistics counters are enabled by defining PARK_GATE_STATS_EN.
module park_gate_ctrl #(
  parameter int CAPACITY     = 12,
  parameter int CNT_W        = 4,
  parameter int GATE_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             entry_pass,
  input  logic             exit_req,
  input  logic             exit_pass,
`ifdef PARK_GATE_STATS_EN
  output logic [15:0]      total_entries,
  output logic [15:0]      total_denied,
`endif
  output logic [CNT_W-1:0] count,
  output logic             entry_open,
  output logic             exit_open,
  output logic             entry_denied,
  output logic             gate_timeout,
  output logic             exit_err
);

  localparam int TW = (GATE_TIMEOUT > 2) ? $clog2(GATE_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(GATE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} gate_t;

  gate_t en_state, en_next;
  gate_t ex_state, ex_next;
  logic [TW-1:0] en_timer, ex_timer;
  logic en_req_q, en_pass_q, ex_req_q, ex_pass_q;

  logic en_req_rise, en_pass_rise, ex_req_rise, ex_pass_rise;
  logic en_pass_ev, ex_pass_ev, en_to, ex_to, en_deny;

  assign en_req_rise  = entry_req & ~en_req_q;
  assign en_pass_rise = entry_pass & ~en_pass_q;
  assign ex_req_rise  = exit_req & ~ex_req_q;
  assign ex_pass_rise = exit_pass & ~ex_pass_q;

  assign en_pass_ev = (en_state == OPEN) & en_pass_rise;
  assign ex_pass_ev = (ex_state == OPEN) & ex_pass_rise;
  assign en_to = (en_state == OPEN) & ~en_pass_rise & (en_timer == LAST);
  assign ex_to = (ex_state == OPEN) & ~ex_pass_rise & (ex_timer == LAST);
  assign en_deny = (en_state == IDLE) & en_req_rise & (count >= CAP);

  // Sensor history for rise detection
  always_ff @(posedge clk) begin
    if (rst) begin
      en_req_q  <= 1'b0;
      en_pass_q <= 1'b0;
      ex_req_q  <= 1'b0;
      ex_pass_q <= 1'b0;
    end else begin
      en_req_q  <= entry_req;
      en_pass_q <= entry_pass;
      ex_req_q  <= exit_req;
      ex_pass_q <= exit_pass;
    end
  end

  // State registers and open-time timers; timer restarts on each OPEN entry
  always_ff @(posedge clk) begin
    if (rst) begin
      en_state <= IDLE;
      ex_state <= IDLE;
      en_timer <= '0;
      ex_timer <= '0;
    end else begin
      en_state <= en_next;
      ex_state <= ex_next;
      if (en_next == OPEN && en_state != OPEN) en_timer <= '0;
      else if (en_state == OPEN)               en_timer <= en_timer + 1'b1;
      if (ex_next == OPEN && ex_state != OPEN) ex_timer <= '0;
      else if (ex_state == OPEN)               ex_timer <= ex_timer + 1'b1;
    end
  end

  // Next-state logic for both barriers; pass beats timeout on the same edge
  always_comb begin
    en_next = en_state;
    unique case (en_state)
      IDLE:    if (en_req_rise && count < CAP) en_next = OPEN;
      OPEN:    if (en_pass_rise)      en_next = CLOSE;
               else if (en_to)        en_next = IDLE;
      CLOSE:   en_next = IDLE;
      default: en_next = IDLE;
    endcase
    ex_next = ex_state;
    unique case (ex_state)
      IDLE:    if (ex_req_rise)  ex_next = OPEN;
      OPEN:    if (ex_pass_rise) ex_next = CLOSE;
               else if (ex_to)   ex_next = IDLE;
      CLOSE:   ex_next = IDLE;
      default: ex_next = IDLE;
    endcase
  end

  // Barrier outputs decoded from the state registers
  always_comb begin
    entry_open = (en_state == OPEN);
    exit_open  = (ex_state == OPEN);
  end

  // Occupancy counter and event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      entry_denied <= 1'b0;
      gate_timeout <= 1'b0;
      exit_err     <= 1'b0;
    end else begin
      entry_denied <= en_deny;
      gate_timeout <= en_to | ex_to;
      exit_err     <= 1'b0;
      if (en_pass_ev && !ex_pass_ev) begin
        if (count < CAP) count <= count + 1'b1;
      end else if (ex_pass_ev && !en_pass_ev) begin
        if (count != '0) count <= count - 1'b1;
        else             exit_err <= 1'b1;
      end
    end
  end

`ifdef PARK_GATE_STATS_EN
  // Wrapping statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      total_entries <= '0;
      total_denied  <= '0;
    end else begin
      if (en_pass_ev) total_entries <= total_entries + 16'd1;
      if (en_deny)    total_denied  <= total_denied + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Directed testbench for park_gate_ctrl.
// Checks occupancy, barrier sequencing, denial, timeout and reset.
module tb_park_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       entry_req = 1'b0;
  logic       entry_pass = 1'b0;
  logic       exit_req = 1'b0;
  logic       exit_pass = 1'b0;
  logic [3:0] count;
  logic       entry_open, exit_open;
  logic       entry_denied, gate_timeout, exit_err;
`ifdef PARK_GATE_STATS_EN
  logic [15:0] total_entries, total_denied;
`endif

  int n_chk = 0;
  int n_fail = 0;

  park_gate_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .entry_req    (entry_req),
    .entry_pass   (entry_pass),
    .exit_req     (exit_req),
    .exit_pass    (exit_pass),
`ifdef PARK_GATE_STATS_EN
    .total_entries(total_entries),
    .total_denied (total_denied),
`endif
    .count        (count),
    .entry_open   (entry_open),
    .exit_open    (exit_open),
    .entry_denied (entry_denied),
    .gate_timeout (gate_timeout),
    .exit_err     (exit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_entry();
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    step();
    entry_pass = 1'b1;
    step();
    entry_pass = 1'b0;
    step();
  endtask

  task automatic do_exit();
    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    step();
    exit_pass = 1'b1;
    step();
    exit_pass = 1'b0;
    step();
  endtask

  initial begin
    int opens;
    int tos;
    int dens;

    step();
    step();
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_entry_open", entry_open, 0);
    check("rst_exit_open", exit_open, 0);
    check("rst_pulses", {entry_denied, gate_timeout, exit_err}, 0);

    // first entry, pass three cycles after the request edge
    entry_req = 1'b1;
    step();
    check("e1_open", entry_open, 1);
    entry_req = 1'b0;
    step();
    check("e1_open_hold", entry_open, 1);
    step();
    entry_pass = 1'b1;
    step();
    check("e1_count", count, 1);
    check("e1_close", entry_open, 0);
    entry_pass = 1'b0;
    step();
    check("e1_idle", entry_open, 0);
    check("e1_count_hold", count, 1);

    // fill the lot
    for (int i = 0; i < 11; i++) do_entry();
    check("full_count", count, 12);

    // 13th request is refused
    dens = 0;
    opens = 0;
    entry_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      entry_req = 1'b0;
      dens += int'(entry_denied);
      opens += int'(entry_open);
    end
    check("deny_pulses", dens, 1);
    check("deny_open", opens, 0);
    check("deny_count", count, 12);

    // exit frees a space, then entry admitted again
    exit_req = 1'b1;
    step();
    check("x1_open", exit_open, 1);
    exit_req = 1'b0;
    step();
    exit_pass = 1'b1;
    step();
    check("x1_count", count, 11);
    check("x1_err", exit_err, 0);
    exit_pass = 1'b0;
    step();
    do_entry();
    check("refill_count", count, 12);

    // entry timeout with no pass
    do_exit();
    check("pre_to_count", count, 11);
    opens = 0;
    tos = 0;
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      opens += int'(entry_open);
      tos += int'(gate_timeout);
      step();
    end
    check("to_open_cycles", opens, 16);
    check("to_pulses", tos, 1);
    check("to_count", count, 11);

    // simultaneous passes at count 5
    for (int i = 0; i < 6; i++) do_exit();
    check("five_count", count, 5);
    entry_req = 1'b1;
    exit_req = 1'b1;
    step();
    check("both_open", {entry_open, exit_open}, 3);
    entry_req = 1'b0;
    exit_req = 1'b0;
    step();
    entry_pass = 1'b1;
    exit_pass = 1'b1;
    step();
    check("both_count", count, 5);
    check("both_close", {entry_open, exit_open}, 0);
    check("both_pulses", {gate_timeout, exit_err}, 0);
    entry_pass = 1'b0;
    exit_pass = 1'b0;
    step();
    check("both_after", count, 5);

    // underflow exit
    for (int i = 0; i < 5; i++) do_exit();
    check("zero_count", count, 0);
    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    step();
    exit_pass = 1'b1;
    step();
    check("uf_count", count, 0);
    check("uf_err", exit_err, 1);
    exit_pass = 1'b0;
    step();
    check("uf_err_once", exit_err, 0);

    // reset while entry barrier is open
    do_entry();
    check("pre_rst_count", count, 1);
    entry_req = 1'b1;
    step();
    check("pre_rst_open", entry_open, 1);
    entry_req = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_open", entry_open, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_pulses", {entry_denied, gate_timeout, exit_err}, 0);
    rst = 1'b0;
    step();
    check("post_rst_open", entry_open, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
